// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_ext family.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Default geometry and flag thresholds
    localparam int FIFO_DEF_DEPTH        = 16;
    localparam int FIFO_DEF_DWIDTH       = 8;
    localparam int FIFO_DEF_AFULL_MARGIN = 4;
    localparam int FIFO_DEF_AEMPTY_TH    = 2;

    // Ceiling log2 for tools without a usable $clog2
    function automatic int fifo_clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array, DEPTH x DWIDTH.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller only asserts we when space exists.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEF_DEPTH,
    parameter int DWIDTH = FIFO_DEF_DWIDTH
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [fifo_clog2(DEPTH)-1:0]  waddr,
    input  logic [DWIDTH-1:0]             wdata,
    input  logic [fifo_clog2(DEPTH)-1:0]  raddr,
    output logic [DWIDTH-1:0]             rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage is not reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with standard or first-word-fall-through read, count and sticky error flags.
// Latency: standard read data 1 cycle after rd_en; FWFT data visible the edge after the first write.
// Backpressure: writes while full are dropped (overflow), reads while empty are ignored (underflow).
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int DWIDTH    = FIFO_DEF_DWIDTH,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AFULL_TH  = DEPTH - FIFO_DEF_AFULL_MARGIN,
    parameter int AEMPTY_TH = FIFO_DEF_AEMPTY_TH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);
    localparam logic [PW-1:0] ONE_C    = PW'(1);

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [DWIDTH-1:0] ram_rdata;

    // Acceptance looks only at registered flags, so no request-to-flag combinational path
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // Pointers and occupancy; flush returns them to the post-reset state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE_C;
            end
            if (rd_acc) begin
                rptr <= rptr + ONE_C;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + ONE_C;
            end else if (rd_acc && !wr_acc) begin
                count <= count - ONE_C;
            end
        end
    end

    // Sticky error flags; a rejected request still records the error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (din),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign dout       = ram_rdata;
            assign dout_valid = ~empty;
        end else begin : g_std
            logic [DWIDTH-1:0] dout_q;
            logic              vld_q;

            // Registered read port: dout loads on an accepted read and holds otherwise
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= ram_rdata;
                    end
                end
            end

            assign dout       = dout_q;
            assign dout_valid = vld_q;
        end
    endgenerate

    // The wide pointers always differ by exactly the occupancy
    ptr_count_consistent: assert property (@(posedge clk) disable iff (!rstn)
        (count == PW'(wptr - rptr)));

endmodule
